// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate generator with a 2-entry skid buffer and a tag sideband.
// Define IMM_GEN_ILLEGAL_EN to add the out_err unknown-opcode flag.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [TAG_W-1:0] out_tag
`ifdef IMM_GEN_ILLEGAL_EN
  ,
  output logic             out_err
`endif
);
  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
`ifdef IMM_GEN_ILLEGAL_EN
  localparam int EW = 1;
`else
  localparam int EW = 0;
`endif
  localparam int PW = EW + 3 + XLEN + TAG_W;

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  logic [6:0]      w_op;
  logic            w_i;
  logic [2:0]      w_fmt;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic [PW-1:0]   w_pay;
  logic            w_acc;
  logic            w_load_out;
  logic            r_out_valid;
  logic            r_skid_valid;
  logic [PW-1:0]   r_out;
  logic [PW-1:0]   r_skid;

  // every format's 32-bit immediate has its sign in bit 31, so one signed cast widens to XLEN
  always_comb begin
    w_op = in_instr[6:0];
    w_i = w_op == 7'b0000011 || w_op == 7'b0010011 || w_op == 7'b1100111 ||
          (XLEN == 64 && w_op == 7'b0011011);
    w_fmt = w_i ? FMT_I :
            w_op == 7'b0100011 ? FMT_S :
            w_op == 7'b1100011 ? FMT_B :
            (w_op == 7'b0110111 || w_op == 7'b0010111) ? FMT_U :
            w_op == 7'b1101111 ? FMT_J : FMT_NONE;
    w_imm32 = w_fmt == FMT_I ? {{20{in_instr[31]}}, in_instr[31:20]} :
              w_fmt == FMT_S ? {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]} :
              w_fmt == FMT_B ? {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0} :
              w_fmt == FMT_U ? {in_instr[31:12], 12'b0} :
              w_fmt == FMT_J ? {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0} :
              32'b0;
    w_imm = XLEN'($signed(w_imm32));
  end

`ifdef IMM_GEN_ILLEGAL_EN
  assign w_pay = {w_fmt == FMT_NONE, w_fmt, w_imm, in_tag};
  assign {out_err, out_fmt, out_imm, out_tag} = r_out;
`else
  assign w_pay = {w_fmt, w_imm, in_tag};
  assign {out_fmt, out_imm, out_tag} = r_out;
`endif

  assign in_ready   = !r_skid_valid;
  assign out_valid  = r_out_valid;
  assign w_acc      = in_valid && !r_skid_valid && !flush;
  assign w_load_out = !r_out_valid || out_ready;

  // the output register refills from skid first, so ordering stays FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out        <= '0;
      r_skid       <= '0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      if (w_load_out) begin
        r_out_valid <= r_skid_valid || w_acc;
        if (r_skid_valid) r_out <= r_skid;
        else if (w_acc) r_out <= w_pay;
      end
      r_skid_valid <= r_skid_valid ? !w_load_out : (w_acc && !w_load_out);
      if (w_acc && !w_load_out) r_skid <= w_pay;
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed + random checks of imm_gen_pipe (XLEN 32 and 64 instances) against a queue model.
module tb_imm_gen_pipe;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_tag = '0;
  logic        in_ready, out_valid, in_ready64, out_valid64;
  logic [31:0] out_imm, out_tag, out_tag64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt, out_fmt64;
`ifdef IMM_GEN_ILLEGAL_EN
  logic        out_err, out_err64;
`endif
  int n_chk = 0, n_fail = 0;

  typedef struct {logic [31:0] instr; logic [31:0] tag;} ent_t;
  ent_t q[$];
  logic [6:0] ops [10] = '{7'h03, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_tag(out_tag)
`ifdef IMM_GEN_ILLEGAL_EN
    , .out_err(out_err)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_tag(out_tag64)
`ifdef IMM_GEN_ILLEGAL_EN
    , .out_err(out_err64)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  function automatic logic [2:0] ref_fmt(input logic [31:0] i, input bit x64);
    case (i[6:0])
      7'h03, 7'h13, 7'h67: return 3'd1;
      7'h1B:               return x64 ? 3'd1 : 3'd0;
      7'h23:               return 3'd2;
      7'h63:               return 3'd3;
      7'h37, 7'h17:        return 3'd4;
      7'h6F:               return 3'd5;
      default:             return 3'd0;
    endcase
  endfunction

  function automatic longint sx(input longint v, input int w);
    return ((v >> (w - 1)) & 1) != 0 ? v - (64'sd1 <<< w) : v;
  endfunction

  function automatic longint ref_imm(input logic [31:0] i, input bit x64);
    case (ref_fmt(i, x64))
      3'd1:    return sx(longint'(i[31:20]), 12);
      3'd2:    return sx(longint'({i[31:25], i[11:7]}), 12);
      3'd3:    return sx(longint'({i[31], i[7], i[30:25], i[11:8], 1'b0}), 13);
      3'd4:    return sx(longint'({i[31:12], 12'b0}), 32);
      3'd5:    return sx(longint'({i[31], i[19:12], i[20], i[30:21], 1'b0}), 21);
      default: return 64'sd0;
    endcase
  endfunction

  task automatic tick();
    bit acc, fire;
    longint v32, v64;
    acc  = in_valid && in_ready && !flush;
    fire = out_valid && out_ready;
    if (flush) q.delete();
    else begin
      if (fire && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back('{in_instr, in_tag});
    end
    @(posedge clk);
    #1;
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
    if (q.size() > 0) begin
      v32 = ref_imm(q[0].instr, 1'b0);
      v64 = ref_imm(q[0].instr, 1'b1);
      chk("imm32", 64'(out_imm), 64'(v32[31:0]));
      chk("fmt32", 64'(out_fmt), 64'(ref_fmt(q[0].instr, 1'b0)));
      chk("tag32", 64'(out_tag), 64'(q[0].tag));
      chk("imm64", out_imm64, v64);
      chk("fmt64", 64'(out_fmt64), 64'(ref_fmt(q[0].instr, 1'b1)));
      chk("tag64", 64'(out_tag64), 64'(q[0].tag));
`ifdef IMM_GEN_ILLEGAL_EN
      chk("err32", 64'(out_err), 64'(ref_fmt(q[0].instr, 1'b0) == 3'd0));
      chk("err64", 64'(out_err64), 64'(ref_fmt(q[0].instr, 1'b1) == 3'd0));
`endif
    end
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] tg);
    in_valid = 1'b1;
    in_instr = ins;
    in_tag   = tg;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    #12;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_imm", 64'(out_imm), 64'd0);
    chk("rst_fmt", 64'(out_fmt), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    send(32'hFFF00093, 32'hA1);
    chk("addi_valid", 64'(out_valid), 64'd1);
    chk("addi_imm", 64'(out_imm), 64'hFFFFFFFF);
    chk("addi_fmt", 64'(out_fmt), 64'd1);
    send(32'h123450B7, 32'hA2);
    chk("lui_imm", 64'(out_imm), 64'h12345000);
    chk("lui_fmt", 64'(out_fmt), 64'd4);
    send(32'hFE000EE3, 32'hA3);
    chk("beq_imm", 64'(out_imm), 64'hFFFFFFFC);
    chk("beq_fmt", 64'(out_fmt), 64'd3);
    send(32'h008000EF, 32'hA4);
    chk("jal_imm", 64'(out_imm), 64'h00000008);
    chk("jal_fmt", 64'(out_fmt), 64'd5);
    send(32'hFE002C23, 32'hA5);
    chk("sw_imm", 64'(out_imm), 64'hFFFFFFF8);
    chk("sw_fmt", 64'(out_fmt), 64'd2);
    send(32'h800000B7, 32'hA6);
    chk("lui64_imm", out_imm64, 64'hFFFFFFFF80000000);
    chk("lui32_imm", 64'(out_imm), 64'h80000000);
    send(32'h0000007F, 32'hA7);
    chk("bad_imm", out_imm64, 64'd0);
    chk("bad_fmt", 64'(out_fmt64), 64'd0);
`ifdef IMM_GEN_ILLEGAL_EN
    chk("bad_err", 64'(out_err64), 64'd1);
`endif
    tick();
    // backpressure: three back-to-back issues against a stalled consumer
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'hFFF00093;
    in_tag = 32'd1;
    tick();
    in_tag = 32'd2;
    tick();
    chk("bp_ready_c2", 64'(in_ready), 64'd0);
    in_tag = 32'd3;
    tick();
    tick();
    chk("bp_hold_tag", 64'(out_tag), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_tag2_valid", 64'(out_valid), 64'd1);
    chk("bp_tag2", 64'(out_tag), 64'd2);
    tick();
    chk("bp_tag3", 64'(out_tag), 64'd3);
    in_valid = 1'b0;
    tick();
    // flush with both entries held and a new instruction offered
    out_ready = 1'b0;
    send(32'h00100093, 32'h10);
    send(32'h00200093, 32'h11);
    chk("fl_full", 64'(in_ready), 64'd0);
    flush = 1'b1;
    in_valid = 1'b1;
    in_tag = 32'h99;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("fl_gone", 64'(out_valid), 64'd0);
    // asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    send(32'h00300093, 32'h20);
    send(32'h00400093, 32'h21);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_ready", 64'(in_ready), 64'd1);
    chk("arst_imm", 64'(out_imm), 64'd0);
    chk("arst_fmt", 64'(out_fmt), 64'd0);
    chk("arst_tag", 64'(out_tag), 64'd0);
    q.delete();
    #3;
    rst = 1'b0;
    out_ready = 1'b1;
    send(32'h123450B7, 32'h30);
    chk("arst_first_valid", 64'(out_valid), 64'd1);
    chk("arst_first_tag", 64'(out_tag), 64'h30);
    // randomized traffic against the queue model
    for (int c = 0; c < 400; c++) begin
      r = $urandom();
      in_valid  = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < 6;
      flush     = $urandom_range(0, 49) == 0;
      in_instr  = {r[31:7], ops[$urandom_range(0, 9)]};
      in_tag    = $urandom();
      tick();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
